// File: rtl/cdc_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
//   Shared constants for the req/ack bus-crossing handshake blocks.
//   - ST_* : FSM state encodings for the transmit side.
//   - CDC_SYNC_STAGES_DEFAULT : default depth of the ack/req synchronizers.
// ---------------------------------------------------------------------------
package cdc_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_ACK_LOW = 2'd2;

    localparam int unsigned CDC_SYNC_STAGES_DEFAULT = 2;

endpackage : cdc_pkg

// File: rtl/cdc_bit_sync.sv
// ---------------------------------------------------------------------------
// cdc_bit_sync
//   Single-bit multi-flop synchronizer. The asynchronous input feeds only
//   the first flop; the output is taken from the last flop of the chain.
//   Ports:
//     clk_i   : destination clock (posedge)
//     rst_n_i : synchronous active-low reset, clears every stage
//     d_i     : asynchronous input bit
//     q_o     : synchronized bit, STAGES cycles of latency
// ---------------------------------------------------------------------------
module cdc_bit_sync
    import cdc_pkg::*;
#(
    parameter int unsigned STAGES = CDC_SYNC_STAGES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : cdc_bit_sync

// File: rtl/cdc_handshake_tx.sv
// ---------------------------------------------------------------------------
// cdc_handshake_tx
//   Transmit end of a 4-phase req/ack bus-crossing handshake. A word taken
//   from the upstream valid/ready port is held on xfer_data_o while
//   xfer_req_o is high; the far-domain ack is synchronized locally and the
//   full req-up / ack-up / req-down / ack-down sequence completes before the
//   next word is accepted. An optional timeout aborts a request that is
//   never acknowledged.
//   Ports:
//     clk_i, rst_n_i      : source clock, synchronous active-low reset
//     src_valid_i/data_i  : upstream word offer
//     src_ready_o         : word accepted on this cycle if valid is high
//     xfer_req_o          : registered request to destination domain
//     xfer_data_o         : registered word, stable while req is high
//     xfer_ack_i          : asynchronous acknowledge from destination
//     busy_o              : FSM not idle
//     done_o              : one-cycle pulse on normal completion
//     timeout_o           : one-cycle pulse when a request is aborted
// ---------------------------------------------------------------------------
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned SYNC_STAGES    = CDC_SYNC_STAGES_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  src_valid_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    output logic                  src_ready_o,
    output logic                  xfer_req_o,
    output logic [DATA_WIDTH-1:0] xfer_data_o,
    input  logic                  xfer_ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o
);

    localparam logic                 TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic                  ack_s;

    logic [1:0]            state_q,   state_d;
    logic                  req_q,     req_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
    logic                  done_q,    done_d;
    logic                  timeout_q, timeout_d;
    // Set when the current transfer was aborted, so that the ACK_LOW exit
    // does not report it as a completion.
    logic                  aborted_q, aborted_d;

    logic                  src_ready;
    logic                  timeout_hit;

    cdc_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (xfer_ack_i),
        .q_o     (ack_s)
    );

    // A stale ack (e.g. still high from before a reset) must drain before a
    // new request may be raised, otherwise the 4-phase protocol would slip.
    assign src_ready   = (state_q == ST_IDLE) && !ack_s;
    assign timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        aborted_d = aborted_q;

        case (state_q)
            ST_IDLE: begin
                if (src_valid_i && src_ready) begin
                    data_d    = src_data_i;
                    req_d     = 1'b1;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = ST_REQ;
                end
            end

            ST_REQ: begin
                // Ack is checked first so that a late ack coinciding with the
                // timeout limit still completes normally.
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ST_ACK_LOW;
                end else if (timeout_hit) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = ST_ACK_LOW;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_ACK_LOW: begin
                if (!ack_s) begin
                    done_d    = !aborted_q;
                    aborted_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            aborted_q <= aborted_d;
        end
    end

    assign src_ready_o = src_ready;
    assign xfer_req_o  = req_q;
    assign xfer_data_o = data_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;

endmodule : cdc_handshake_tx

// File: tb/tb_cdc_handshake_tx.sv
// ---------------------------------------------------------------------------
// tb_cdc_handshake_tx
//   Directed bench for cdc_handshake_tx. Instance A uses TIMEOUT_CYCLES=10
//   with a delayed-echo ack responder; instance B uses TIMEOUT_CYCLES=4 with
//   a hand-driven ack to exercise the ack/timeout tie and the round trip.
// ---------------------------------------------------------------------------
module tb_cdc_handshake_tx;

    localparam int unsigned SYNC = 2;

    logic       clk;
    logic       rst_n;

    // Instance A
    logic       valid_a;
    logic [7:0] data_a;
    logic       ready_a;
    logic       req_a;
    logic [7:0] xdata_a;
    logic       ack_a;
    logic       busy_a;
    logic       done_a;
    logic       tmo_a;

    // Instance B
    logic       valid_b;
    logic [7:0] data_b;
    logic       ready_b;
    logic       req_b;
    logic [7:0] xdata_b;
    logic       ack_b;
    logic       busy_b;
    logic       done_b;
    logic       tmo_b;

    // Responder for instance A: ack follows req delayed by resp_delay edges
    logic       resp_en;
    logic       ack_manual;
    logic       resp_ack;
    logic [2:0] resp_delay;
    logic [7:0] hist;

    int errors;
    int checks;
    int done_cnt_a, tmo_cnt_a, done_cnt_b, tmo_cnt_b;
    int stab_err;
    logic       req_prev;
    logic [7:0] data_prev;

    assign ack_a = resp_en ? resp_ack : ack_manual;

    cdc_handshake_tx #(
        .DATA_WIDTH     (8),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (10),
        .CNT_WIDTH      (16)
    ) dut_a (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .src_valid_i (valid_a),
        .src_data_i  (data_a),
        .src_ready_o (ready_a),
        .xfer_req_o  (req_a),
        .xfer_data_o (xdata_a),
        .xfer_ack_i  (ack_a),
        .busy_o      (busy_a),
        .done_o      (done_a),
        .timeout_o   (tmo_a)
    );

    cdc_handshake_tx #(
        .DATA_WIDTH     (8),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (4),
        .CNT_WIDTH      (16)
    ) dut_b (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .src_valid_i (valid_b),
        .src_data_i  (data_b),
        .src_ready_o (ready_b),
        .xfer_req_o  (req_b),
        .xfer_data_o (xdata_b),
        .xfer_ack_i  (ack_b),
        .busy_o      (busy_b),
        .done_o      (done_b),
        .timeout_o   (tmo_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        hist     = '0;
        resp_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            hist     = {hist[6:0], req_a};
            resp_ack = hist[resp_delay];
        end
    end

    initial begin
        done_cnt_a = 0; tmo_cnt_a = 0; done_cnt_b = 0; tmo_cnt_b = 0;
        stab_err = 0; req_prev = 1'b0; data_prev = '0;
        forever begin
            @(negedge clk);
            if (done_a) done_cnt_a++;
            if (tmo_a)  tmo_cnt_a++;
            if (done_b) done_cnt_b++;
            if (tmo_b)  tmo_cnt_b++;
            if (req_a && req_prev && (xdata_a !== data_prev)) stab_err++;
            req_prev  = req_a;
            data_prev = xdata_a;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a(input int budget);
        int n;
        n = 0;
        while (!ready_a && n < budget) begin
            tick();
            n++;
        end
        check("wait_ready_a", ready_a, 1'b1);
    endtask

    initial begin
        int n;
        int d0, t0, db0, tb0;
        logic seen_fall;

        errors = 0; checks = 0;
        rst_n = 1'b0;
        valid_a = 1'b0; data_a = '0;
        valid_b = 1'b0; data_b = '0; ack_b = 1'b0;
        resp_en = 1'b1; resp_delay = 3'd3; ack_manual = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_req_a",   req_a,   1'b0);
        check("rst_data_a",  xdata_a, 8'h00);
        check("rst_busy_a",  busy_a,  1'b0);
        check("rst_done_a",  done_a,  1'b0);
        check("rst_tmo_a",   tmo_a,   1'b0);
        check("rst_req_b",   req_b,   1'b0);
        check("rst_data_b",  xdata_b, 8'h00);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", ready_a, 1'b1);

        // ---------------- single transfer A5 ----------------
        d0 = done_cnt_a; t0 = tmo_cnt_a;
        valid_a = 1'b1; data_a = 8'hA5;
        check("t1_req_before", req_a, 1'b0);
        tick();
        valid_a = 1'b0; data_a = 8'h00;
        check("t1_req_rise",  req_a,   1'b1);
        check("t1_data",      xdata_a, 8'hA5);
        check("t1_busy",      busy_a,  1'b1);
        check("t1_ready_low", ready_a, 1'b0);
        wait_ready_a(40);
        check("t1_done_at_ready", done_a, 1'b1);
        repeat (3) tick();
        check("t1_done_once", done_cnt_a - d0, 1);
        check("t1_no_tmo",    tmo_cnt_a - t0,  0);
        check("t1_data_hold", xdata_a, 8'hA5);

        // ---------------- back-to-back 01,02,03 ----------------
        d0 = done_cnt_a; t0 = tmo_cnt_a;
        valid_a = 1'b1; data_a = 8'h01;
        for (int w = 1; w <= 3; w++) begin
            tick();
            if (w == 3) valid_a = 1'b0;
            data_a = 8'(w + 1);
            check("b2b_data",      xdata_a, 32'(w));
            check("b2b_req",       req_a,   1'b1);
            check("b2b_ready_low", ready_a, 1'b0);
            wait_ready_a(40);
            check("b2b_done_at_ready", done_a, 1'b1);
        end
        tick();
        check("b2b_done_cnt", done_cnt_a - d0, 3);
        check("b2b_no_tmo",   tmo_cnt_a - t0,  0);
        check("b2b_stable",   stab_err,        0);

        // ---------------- timeout with ack tied low ----------------
        resp_en = 1'b0; ack_manual = 1'b0;
        d0 = done_cnt_a; t0 = tmo_cnt_a;
        valid_a = 1'b1; data_a = 8'h3C;
        tick();
        valid_a = 1'b0;
        n = 0;
        while (req_a && n < 30) begin
            n++;
            tick();
        end
        check("to_req_cycles", n,      10);
        check("to_pulse",      tmo_a,  1'b1);
        check("to_no_done",    done_a, 1'b0);
        tick();
        check("to_pulse_end",  tmo_a,   1'b0);
        check("to_ready_back", ready_a, 1'b1);
        resp_en = 1'b1; resp_delay = 3'd1;
        valid_a = 1'b1; data_a = 8'h5A;
        tick();
        valid_a = 1'b0;
        check("to_next_req",  req_a,   1'b1);
        check("to_next_data", xdata_a, 8'h5A);
        wait_ready_a(40);
        tick();
        check("to_tmo_cnt",  tmo_cnt_a - t0,  1);
        check("to_done_cnt", done_cnt_a - d0, 1);

        // ---------------- stale ack across reset ----------------
        resp_en = 1'b0; ack_manual = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (SYNC + 1) tick();
        check("stale_ready0", ready_a, 1'b0);
        repeat (4) tick();
        check("stale_ready0_hold", ready_a, 1'b0);
        ack_manual = 1'b0;
        tick();
        check("stale_ready_early", ready_a, 1'b0);
        repeat (SYNC) tick();
        check("stale_ready1", ready_a, 1'b1);

        // ---------------- reset while in REQ with ack high ----------------
        resp_en = 1'b1; resp_delay = 3'd1;
        repeat (3) tick();
        d0 = done_cnt_a; t0 = tmo_cnt_a;
        valid_a = 1'b1; data_a = 8'hC3;
        tick();
        valid_a = 1'b0;
        tick();
        tick();
        check("mr_in_req", req_a, 1'b1);
        check("mr_ack_hi", ack_a, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_req",  req_a,   1'b0);
        check("mr_data", xdata_a, 8'h00);
        check("mr_busy", busy_a,  1'b0);
        repeat (15) tick();
        check("mr_no_done",  done_cnt_a - d0, 0);
        check("mr_no_tmo",   tmo_cnt_a - t0,  0);
        check("mr_ready",    ready_a, 1'b1);

        // ---------------- ack/timeout tie on instance B ----------------
        db0 = done_cnt_b; tb0 = tmo_cnt_b;
        check("tie_ready_pre", ready_b, 1'b1);
        valid_b = 1'b1; data_b = 8'h96;
        tick();
        valid_b = 1'b0;
        check("tie_req",  req_b,   1'b1);
        check("tie_data", xdata_b, 8'h96);
        n = 0;
        seen_fall = 1'b0;
        tick();
        n++;
        ack_b = 1'b1;
        while (!ready_b && n < 40) begin
            tick();
            n++;
            if (seen_fall) ack_b = 1'b0;
            if (!req_b) seen_fall = 1'b1;
        end
        check("tie_round_trip", n, 2 * SYNC + 4);
        check("tie_done",       done_b, 1'b1);
        tick();
        check("tie_done_cnt", done_cnt_b - db0, 1);
        check("tie_no_tmo",   tmo_cnt_b - tb0,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cdc_handshake_tx
